boot_sram_bridge: RTL
=====================

# boot_sram_bridge

Downstream stage of the housekeeping boot loader: captures the one-cycle SRAM write strobes produced during flash boot and commits them to the shared SRAM through a request/grant port. The housekeeping side has no backpressure, so strobes are buffered in a small FIFO. Core enable and boot-done are released to the rest of the chip only after every buffered word has been granted. A running checksum and word count of committed data are exported for debug.

## Interface
- FIFO_DEPTH, 4, buffer entries; power of two, ≥2
- CNT_W, 16, width of committed-word counter
- clk_i  in  1  single system clock
- reset_i  in  1  synchronous, active-high reset
- hk_wr_en_i  in  1  one-cycle write strobe from housekeeping
- hk_addr_i  in  32  write address, valid with strobe
- hk_data_i  in  32  write data, valid with strobe
- hk_boot_done_i  in  1  housekeeping boot finished (level)
- hk_cores_en_i  in  1  housekeeping core-enable request (level)
- mem_req_o  out  1  SRAM write request
- mem_addr_o  out  32  SRAM address, stable while req && !gnt
- mem_wdata_o  out  32  SRAM data, stable while req && !gnt
- mem_gnt_i  in  1  SRAM grant; completes the write in the same cycle
- cores_en_o  out  1  core enable to the cluster
- boot_done_o  out  1  all boot writes committed
- overflow_o  out  1  sticky: a strobe was dropped
- checksum_o  out  32  sum mod 2^32 of granted data words
- words_o  out  CNT_W  count of granted words, wraps mod 2^CNT_W

## Operation
- Reset: FIFO empty, state BOOTING; all outputs 0.
- Push: hk_wr_en_i pushes {addr, data}, except when the FIFO is full and no pop occurs in the same cycle. A dropped push sets overflow_o until reset.
- Full FIFO with a simultaneous push and pop: push accepted, no overflow.
- Memory port: mem_req_o = FIFO not empty. Head entry drives mem_addr_o/mem_wdata_o. A grant pops the head.
- mem_gnt_i while mem_req_o=0 is ignored.
- On each granted word: checksum_o += data; words_o += 1.
- FSM:
  - BOOTING → FLUSH when hk_boot_done_i=1.
  - FLUSH → RELEASED when the FIFO is empty and there is no push that cycle.
  - RELEASED is terminal until reset.
- Outputs in RELEASED:
  - boot_done_o=1.
  - cores_en_o = hk_cores_en_i && !overflow_o, re-evaluated every cycle.
- Strobe in FLUSH: still accepted; it delays the release.
- Strobe in RELEASED: dropped and sets overflow_o. Because cores_en_o tracks overflow_o, the cores are disabled.
- Reset asserted mid-operation: FIFO contents discarded, counters cleared, state returns to BOOTING, mem_req_o=0 in the following cycle.

## Timing
- Strobe at cycle N into an empty FIFO → mem_req_o=1 at N+1.
- Grant at N with a further entry queued → next entry presented at N+1; sustained throughput 1 word/cycle.
- hk_boot_done_i at N with the FIFO empty → FLUSH at N+1, RELEASED (boot_done_o=1) at N+2.
- Strobe and hk_boot_done_i in the same cycle: the write is enqueued first; the release waits for its grant.
- checksum_o and words_o update the cycle after the grant.
- overflow_o rises the cycle after the drop.
- All outputs are registered except mem_req_o/mem_addr_o/mem_wdata_o, which are driven directly from FIFO registers.

## Structure
- Package boot_bridge_pkg holds:
  - typedef enum logic [1:0] bridge_state_t {BOOTING, FLUSH, RELEASED}
  - typedef struct packed boot_wr_t {addr[31:0], data[31:0]}
  - constant BOOT_BRIDGE_DEPTH_DEFAULT = 4
- Sub-module: hk_sync_fifo, a parameterised register FIFO with push/pop/full/empty/head, pointer width $clog2(depth)+1.
- Top level holds the FSM, counters and the overflow flag.

## Test plan
- Single write 0x0000_0010/0xDEAD_BEEF, mem_gnt_i tied 1 → one request at N+1; checksum_o=0xDEADBEEF, words_o=1.
- Five strobes on consecutive cycles, grant held 0 → overflow_o=1 after the 5th. Then grant 1 → 4 words committed in order. hk_boot_done_i=1, hk_cores_en_i=1 → boot_done_o=1, cores_en_o=0.
- Grant withheld 3 cycles → addr/data stable, no pop. Grant on alternate cycles → order preserved.
- hk_boot_done_i in the same cycle as the last strobe → boot_done_o rises only after that word's grant plus 2 cycles.
- Data 0xFFFF_FFFF then 0x0000_0002 → checksum_o=0x0000_0001 (wrap).
- Reset asserted while 3 entries are queued → next cycle mem_req_o=0, words_o=0, state BOOTING; a subsequent boot completes normally.

Source files
------------

// File: rtl/boot_bridge_pkg.sv
// rtl/boot_bridge_pkg.sv - shared types and constants for the boot SRAM bridge
package boot_bridge_pkg;

    // Bridge lifecycle: collect boot writes, drain them, then hand over the chip.
    typedef enum logic [1:0] {
        BOOTING  = 2'd0,
        FLUSH    = 2'd1,
        RELEASED = 2'd2
    } bridge_state_t;

    // One buffered housekeeping write.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } boot_wr_t;

    localparam int BOOT_BRIDGE_DEPTH_DEFAULT = 4;
    localparam int BOOT_WR_W                 = $bits(boot_wr_t);

endpackage

// File: rtl/hk_sync_fifo.sv
// rtl/hk_sync_fifo.sv - register FIFO buffering housekeeping write strobes
module hk_sync_fifo
    import boot_bridge_pkg::*;
#(
    parameter int DEPTH = BOOT_BRIDGE_DEPTH_DEFAULT,
    parameter int WIDTH = BOOT_WR_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A pop frees the head slot this cycle, so a push into a full FIFO is fine then.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is read straight from storage so the consumer sees it without a bubble.
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for storage and pointers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage is cleared on reset so the idle head (and thus the memory port) reads zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/boot_sram_bridge.sv
// rtl/boot_sram_bridge.sv - commits housekeeping boot writes to SRAM and gates chip release
module boot_sram_bridge
    import boot_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = BOOT_BRIDGE_DEPTH_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             hk_wr_en_i,
    input  logic [31:0]      hk_addr_i,
    input  logic [31:0]      hk_data_i,
    input  logic             hk_boot_done_i,
    input  logic             hk_cores_en_i,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_gnt_i,
    output logic             cores_en_o,
    output logic             boot_done_o,
    output logic             overflow_o,
    output logic [31:0]      checksum_o,
    output logic [CNT_W-1:0] words_o
);

    bridge_state_t    state_q;
    bridge_state_t    state_d;
    logic             overflow_q;
    logic             overflow_d;
    logic [31:0]      checksum_q;
    logic [31:0]      checksum_d;
    logic [CNT_W-1:0] words_q;
    logic [CNT_W-1:0] words_d;
    logic             boot_done_q;
    logic             boot_done_d;
    logic             cores_en_q;
    logic             cores_en_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push_ok;
    boot_wr_t         push_entry;
    boot_wr_t         head_entry;

    // A grant only counts while a request is actually outstanding.
    assign pop = mem_gnt_i && !fifo_empty;

    // After release the SRAM belongs to the cores, so late strobes are refused.
    assign push_ok = hk_wr_en_i && (state_q != RELEASED) && (!fifo_full || pop);

    assign push_entry = '{addr: hk_addr_i, data: hk_data_i};

    hk_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BOOT_WR_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push_ok),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head_entry)
    );

    assign mem_req_o   = !fifo_empty;
    assign mem_addr_o  = head_entry.addr;
    assign mem_wdata_o = head_entry.data;

    // Release only once the buffer has drained and no new strobe is arriving.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOTING:  if (hk_boot_done_i) state_d = FLUSH;
            FLUSH:    if (fifo_empty && !hk_wr_en_i) state_d = RELEASED;
            RELEASED: state_d = RELEASED;
            default:  state_d = BOOTING;
        endcase
    end

    // Debug counters, sticky drop flag and the registered release outputs.
    always_comb begin
        overflow_d = overflow_q || (hk_wr_en_i && !push_ok);
        checksum_d = checksum_q;
        words_d    = words_q;
        if (pop) begin
            checksum_d = checksum_q + head_entry.data;
            words_d    = words_q + 1'b1;
        end
        boot_done_d = (state_d == RELEASED);
        // A dropped write means SRAM contents are incomplete: keep the cores off.
        cores_en_d  = (state_d == RELEASED) && hk_cores_en_i && !overflow_d;
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= BOOTING;
            overflow_q  <= 1'b0;
            checksum_q  <= '0;
            words_q     <= '0;
            boot_done_q <= 1'b0;
            cores_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            checksum_q  <= checksum_d;
            words_q     <= words_d;
            boot_done_q <= boot_done_d;
            cores_en_q  <= cores_en_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign checksum_o  = checksum_q;
    assign words_o     = words_q;
    assign boot_done_o = boot_done_q;
    assign cores_en_o  = cores_en_q;

endmodule
